// File: rtl/hilo_pkg.sv
// ============================================================================
// hilo_pkg : shared types and constants for the HI/LO multiply/divide unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package hilo_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } hilo_state_t;

    localparam int DIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/div_radix2.sv
// ============================================================================
// div_radix2 : unsigned 32-bit restoring radix-2 divider, one bit per cycle
// Revision   : 1.0
// ============================================================================
`default_nettype none

module div_radix2
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam logic [4:0] c_LAST = 5'(DIV_ITERS - 1);

    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divs_q;
    logic [4:0]  cnt_q;
    logic        run_q;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_d;
    logic [31:0] w_quot_d;

    // Remainder is 33 bits wide after the shift, so the trial subtract keeps the carry.
    assign w_shift  = {rem_q, quot_q[31]};
    assign w_diff   = w_shift - {1'b0, divs_q};
    assign w_rem_d  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quot_d = {quot_q[30:0], ~w_diff[32]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= 32'd0;
            quot_q <= 32'd0;
            divs_q <= 32'd0;
            cnt_q  <= 5'd0;
            run_q  <= 1'b0;
        end else if (abort) begin
            cnt_q <= 5'd0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q  <= 32'd0;
            quot_q <= dividend;
            divs_q <= divisor;
            cnt_q  <= 5'd0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= w_rem_d;
            quot_q <= w_quot_d;
            cnt_q  <= (cnt_q == c_LAST) ? 5'd0 : cnt_q + 5'd1;
            run_q  <= (cnt_q != c_LAST);
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = run_q && (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
// hilo_muldiv : multi-cycle multiply/divide unit owning architectural HI/LO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  hilo_op_t    op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    hilo_state_t state_q;
    hilo_op_t    op_q;
    logic [63:0] prod_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        bzero_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        w_accept;
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_mul_signed;
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [63:0] w_hilo;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic        w_div_done;

    assign w_accept     = (state_q == ST_IDLE) && op_valid && !flush;
    assign w_is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign w_div_signed = (op == OP_DIV);
    assign w_mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);

    // A 64x64 product truncated to 64 bits is exact for both extensions.
    assign w_ext_a = w_mul_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign w_ext_b = w_mul_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign w_prod  = w_ext_a * w_ext_b;
    assign w_hilo  = {hi_q, lo_q};

    assign w_sa    = w_div_signed && src_a[31];
    assign w_sb    = w_div_signed && src_b[31];
    assign w_mag_a = w_sa ? (~src_a + 32'd1) : src_a;
    assign w_mag_b = w_sb ? (~src_b + 32'd1) : src_b;

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept && w_is_div),
        .abort     (flush),
        .dividend  (w_mag_a),
        .divisor   (w_mag_b),
        .quotient  (w_quot),
        .remainder (w_rem),
        .done      (w_div_done)
    );

    assign w_quot_fix = neg_quot_q ? (~w_quot + 32'd1) : w_quot;
    assign w_rem_fix  = neg_rem_q  ? (~w_rem  + 32'd1) : w_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            prod_q     <= 64'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            bzero_q    <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (op_valid) begin
                            case (op)
                                OP_MTHI: hi_q <= src_a;
                                OP_MTLO: lo_q <= src_a;
                                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                                OP_MSUB, OP_MSUBU: begin
                                    op_q    <= op;
                                    prod_q  <= w_prod;
                                    state_q <= ST_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    op_q       <= op;
                                    neg_quot_q <= w_sa ^ w_sb;
                                    neg_rem_q  <= w_sa;
                                    bzero_q    <= (src_b == 32'd0);
                                    state_q    <= ST_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        case (op_q)
                            OP_MADD, OP_MADDU: {hi_q, lo_q} <= w_hilo + prod_q;
                            OP_MSUB, OP_MSUBU: {hi_q, lo_q} <= w_hilo - prod_q;
                            default:           {hi_q, lo_q} <= prod_q;
                        endcase
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    ST_DIV: begin
                        if (w_div_done) begin
                            state_q <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (!bzero_q) begin
                            hi_q <= w_rem_fix;
                            lo_q <= w_quot_fix;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire
